warp_scheduler_n: RTL
=====================

// Module: warp_scheduler_n
// PURPOSE
//   Per-core issue scheduler for NUM_WARPS warps that share one decoder, ALU and PC pipeline.
//   Tracks a state per warp and picks the next ready warp round-robin. Parks a warp on a memory
//   op until its LSU reports completion. Supersedes the fixed two-warp warp_select scheme.
// PARAMETERS
//   NUM_WARPS  4  warps multiplexed onto the shared pipeline (>=2)
//   WID_BITS   $clog2(NUM_WARPS)  warp index width (localparam, derived)
// PORTS
//   clk           in   1              core clock
//   reset         in   1              synchronous, active-high reset
//   start         in   NUM_WARPS      per-warp launch pulse
//   done          out  NUM_WARPS      per-warp sticky completion flag
//   issue_valid   out  1              a warp is offered to the shared pipeline
//   issue_warp    out  WID_BITS       offered warp index (the pipeline's warp select)
//   issue_ready   in   1              pipeline accepts issue_warp this cycle
//   retire_valid  in   1              pipeline finished one instruction
//   retire_warp   in   WID_BITS       warp that retired
//   retire_kind   in   2              00 normal, 01 mem (LDR/STR), 10 RET, 11 treated as 00
//   mem_done      in   NUM_WARPS      per-warp LSU completion pulse
//   active_count  out  WID_BITS+1     warps in READY, ISSUED or MEM_WAIT
//   protocol_err  out  1              sticky illegal-retire flag
// BEHAVIOUR
// - Reset: every warp IDLE, done=0, rr_ptr=0, lock=0, issue_valid=0, issue_warp=0,
//   active_count=0, protocol_err=0. Takes effect at the next clk edge and overrides every other input.
// - Per-warp states: IDLE, READY, ISSUED, MEM_WAIT, DONE (3-bit register per warp).
// - Warp transitions:
//   - IDLE/DONE + start[w] -> READY; done[w] clears in the same edge.
//   - start[w] is ignored in READY, ISSUED and MEM_WAIT.
//   - READY + handshake (issue_valid & issue_ready, issue_warp==w) -> ISSUED.
//   - ISSUED + retire_valid, retire_warp==w -> READY (00/11), MEM_WAIT (01), or DONE (10) with done[w]=1.
//   - MEM_WAIT + mem_done[w] -> READY. mem_done[w] in any other state is ignored, including the
//     same cycle as the mem retire.
// - Retire for a warp not in ISSUED: no state change; protocol_err sets and stays set until reset.
// - Arbitration: when lock=0, candidate = first READY warp at or after rr_ptr, wrapping at NUM_WARPS-1 -> 0.
//   - issue_valid = lock | (any READY).
//   - On valid & !ready: lock=1 and the candidate is captured.
//   - issue_warp holds stable while issue_valid & !issue_ready, even if a higher-priority warp becomes READY.
//   - Handshake: lock=0, rr_ptr=issue_warp+1 mod NUM_WARPS.
// - Each warp has at most one instruction in flight. Several different warps may be ISSUED at once.
// - Latency:
//   - start at edge t -> READY after t -> issue_valid visible the cycle after t.
//   - A retire to READY is eligible for issue the following cycle (no same-cycle bypass).
// - issue_valid, issue_warp and active_count depend only on registers (Moore); no input->output
//   combinational path.
// - Simultaneous events on different warps are all applied in the same edge.
// TESTING
// - Reset, start=0001, issue_ready=1, retire normal one cycle after each issue -> issue_warp=0
//   every handshake, active_count=1.
// - start=1111, issue_ready=1, each issue retired normal next cycle -> issue order 0,1,2,3,0,1.
// - Warp 2 READY, issue_ready=0 for 5 cycles, start[0] pulsed -> issue_warp stays 2.
//   Then ready=1 -> handshake on 2, next offer is 0 (wrap via rr_ptr=3).
// - Warp 1 retires kind 01 -> not offered for 10 cycles. mem_done[3] while warp 3 READY is ignored.
//   mem_done[1] -> warp 1 offered the cycle after next edge.
// - Warp 0 retires kind 10 -> done[0]=1, active_count drops by 1. start[0] -> done[0]=0, warp 0 READY.
// - retire_warp=2 while warp 2 READY -> protocol_err=1, states unchanged. Reset mid-run with
//   two warps ISSUED -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/warp_scheduler_n.sv
// Round-robin issue scheduler for NUM_WARPS warps sharing one decode/ALU/PC pipeline.
// Warps park in MEM_WAIT after a memory retire until their LSU reports completion.
module warp_scheduler_n #(
    parameter  int NUM_WARPS = 4,
    localparam int WID_BITS  = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WARPS-1:0] start,
    output logic [NUM_WARPS-1:0] done,
    output logic                 issue_valid,
    output logic [WID_BITS-1:0]  issue_warp,
    input  logic                 issue_ready,
    input  logic                 retire_valid,
    input  logic [WID_BITS-1:0]  retire_warp,
    input  logic [1:0]           retire_kind,
    input  logic [NUM_WARPS-1:0] mem_done,
    output logic [WID_BITS:0]    active_count,
    output logic                 protocol_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READY    = 3'd1,
        ISSUED   = 3'd2,
        MEM_WAIT = 3'd3,
        DONE     = 3'd4
    } warp_state_t;

    localparam logic [1:0] KIND_MEM = 2'b01;
    localparam logic [1:0] KIND_RET = 2'b10;

    warp_state_t          state   [NUM_WARPS];
    warp_state_t          state_n [NUM_WARPS];
    logic [NUM_WARPS-1:0] done_n;
    logic                 err_n;
    logic                 lock;
    logic                 lock_n;
    logic [WID_BITS-1:0]  rr_ptr;
    logic [WID_BITS-1:0]  rr_n;
    logic [WID_BITS-1:0]  warp_n;
    logic [WID_BITS-1:0]  scan_idx;
    logic [WID_BITS:0]    scan_sum;
    logic [WID_BITS:0]    count_n;
    logic                 found_n;
    logic                 handshake;
    logic                 retire_hit;

    // Outputs are registered from the next-state view, so they stay pure functions of flops.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n    = state;
        done_n     = done;
        err_n      = protocol_err;
        lock_n     = lock;
        rr_n       = rr_ptr;
        handshake  = issue_valid && issue_ready;
        retire_hit = 1'b0;

        for (int w = 0; w < NUM_WARPS; w++) begin
            case (state[w])
                IDLE, DONE: begin
                    if (start[w]) begin
                        state_n[w] = READY;
                        done_n[w]  = 1'b0;
                    end
                end
                READY: begin
                    if (handshake && issue_warp == WID_BITS'(w)) state_n[w] = ISSUED;
                end
                ISSUED: begin
                    if (retire_valid && retire_warp == WID_BITS'(w)) begin
                        retire_hit = 1'b1;
                        case (retire_kind)
                            KIND_MEM: state_n[w] = MEM_WAIT;
                            KIND_RET: begin
                                state_n[w] = DONE;
                                done_n[w]  = 1'b1;
                            end
                            default:  state_n[w] = READY;
                        endcase
                    end
                end
                MEM_WAIT: begin
                    if (mem_done[w]) state_n[w] = READY;
                end
                default: state_n[w] = IDLE;
            endcase
        end

        // A retire that matches no in-flight warp is a pipeline bug; flag it and change nothing.
        if (retire_valid && !retire_hit) err_n = 1'b1;

        if (handshake) begin
            lock_n = 1'b0;
            rr_n   = (issue_warp == WID_BITS'(NUM_WARPS - 1)) ? '0 : issue_warp + 1'b1;
        end else if (issue_valid) begin
            lock_n = 1'b1;
        end

        found_n  = 1'b0;
        warp_n   = issue_warp;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            scan_sum = {1'b0, rr_n} + (WID_BITS + 1)'(i);
            if (scan_sum >= (WID_BITS + 1)'(NUM_WARPS)) scan_sum = scan_sum - (WID_BITS + 1)'(NUM_WARPS);
            scan_idx = scan_sum[WID_BITS-1:0];
            if (!found_n && state_n[scan_idx] == READY) begin
                found_n = 1'b1;
                warp_n  = scan_idx;
            end
        end
        // A stalled offer keeps its warp even if a higher-priority warp turns READY.
        if (lock_n) warp_n = issue_warp;

        count_n = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (state_n[w] inside {READY, ISSUED, MEM_WAIT}) count_n = count_n + (WID_BITS + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the per-warp state array is small and architecturally visible, so it is reset like any flop.
            for (int w = 0; w < NUM_WARPS; w++) state[w] <= IDLE;
            done         <= '0;
            rr_ptr       <= '0;
            lock         <= 1'b0;
            issue_valid  <= 1'b0;
            issue_warp   <= '0;
            active_count <= '0;
            protocol_err <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let every register see the same pre-edge values.
            for (int w = 0; w < NUM_WARPS; w++) state[w] <= state_n[w];
            done         <= done_n;
            rr_ptr       <= rr_n;
            lock         <= lock_n;
            issue_valid  <= lock_n || found_n;
            issue_warp   <= warp_n;
            active_count <= count_n;
            protocol_err <= err_n;
        end
    end

endmodule
